// File: rtl/mem_port_arbiter.sv
// Shares one SRAM-like bus port between fetch and load/store, one transaction in flight,
// with fixed MIPS segment translation at grant. Define MEM_ARB_RR_EN for round-robin priority.
module mem_port_arbiter #(
    parameter bit KSEG1_UNCACHED = 1'b1,
    parameter bit DATA_FIRST     = 1'b1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        inst_req,
    input  logic [31:0] inst_addr,
    output logic        inst_addr_ok,
    output logic        inst_data_ok,
    output logic [31:0] inst_rdata,
    input  logic        data_req,
    input  logic        data_wr,
    input  logic [1:0]  data_size,
    input  logic [31:0] data_addr,
    input  logic [31:0] data_wdata,
    output logic        data_addr_ok,
    output logic        data_data_ok,
    output logic [31:0] data_rdata,
    output logic        mem_req,
    output logic        mem_wr,
    output logic [1:0]  mem_size,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic        mem_uncached,
    input  logic        mem_addr_ok,
    input  logic        mem_data_ok,
    input  logic [31:0] mem_rdata
);

    typedef enum logic [1:0] {IDLE, ADDR, DATA} state_t;
    typedef enum logic {OWN_INST = 1'b0, OWN_DATA = 1'b1} owner_t;

    state_t state, state_next;
    owner_t owner;
    logic   grant_inst, grant_data;
    logic   prefer_data;
    logic [31:0] sel_vaddr;

    function automatic logic [31:0] xlate(input logic [31:0] va);
        logic [3:0] top;
        case (va[31:28])
            4'h8, 4'h9: top = va[31:28] - 4'h8;
            4'hA, 4'hB: top = va[31:28] - 4'hA;
            default:    top = va[31:28];
        endcase
        return {top, va[27:0]};
    endfunction

`ifdef MEM_ARB_RR_EN
    owner_t last_win;

    // Under contention the requester that did not win last goes first.
    always_ff @(posedge clk) begin
        if (reset)           last_win <= OWN_INST;
        else if (grant_inst) last_win <= OWN_INST;
        else if (grant_data) last_win <= OWN_DATA;
    end

    assign prefer_data = (last_win == OWN_INST);
`else
    assign prefer_data = DATA_FIRST;
`endif

    always_comb begin
        state_next = state;
        grant_inst = 1'b0;
        grant_data = 1'b0;
        case (state)
            IDLE: begin
                if (!reset) begin
                    if (data_req && (prefer_data || !inst_req)) grant_data = 1'b1;
                    else if (inst_req)                          grant_inst = 1'b1;
                end
                if (grant_inst || grant_data) state_next = ADDR;
            end
            // A data_ok arriving alongside addr_ok is not ours yet; only addr_ok counts here.
            ADDR:    if (mem_addr_ok) state_next = DATA;
            DATA:    if (mem_data_ok) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    assign inst_addr_ok = grant_inst;
    assign data_addr_ok = grant_data;
    assign inst_data_ok = !reset && (state == DATA) && (owner == OWN_INST) && mem_data_ok;
    assign data_data_ok = !reset && (state == DATA) && (owner == OWN_DATA) && mem_data_ok;
    assign inst_rdata   = mem_rdata;
    assign data_rdata   = mem_rdata;
    assign sel_vaddr    = grant_data ? data_addr : inst_addr;

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            mem_req      <= 1'b0;
            mem_wr       <= 1'b0;
            mem_size     <= 2'd0;
            mem_addr     <= 32'd0;
            mem_wdata    <= 32'd0;
            mem_uncached <= 1'b0;
            owner        <= OWN_INST;
        end else begin
            case (state)
                IDLE: if (grant_inst || grant_data) begin
                    mem_req      <= 1'b1;
                    mem_wr       <= grant_data & data_wr;
                    mem_size     <= grant_data ? data_size : 2'd2;
                    mem_addr     <= xlate(sel_vaddr);
                    mem_wdata    <= grant_data ? data_wdata : 32'd0;
                    mem_uncached <= KSEG1_UNCACHED && (sel_vaddr[31:29] == 3'b101);
                    owner        <= grant_data ? OWN_DATA : OWN_INST;
                end
                ADDR: if (mem_addr_ok) mem_req <= 1'b0;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: table-driven single transactions plus
// contention, bus stall and reset-mid-transaction sequences.
module tb_mem_port_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        inst_req, inst_addr_ok, inst_data_ok;
    logic [31:0] inst_addr, inst_rdata;
    logic        data_req, data_wr, data_addr_ok, data_data_ok;
    logic [1:0]  data_size;
    logic [31:0] data_addr, data_wdata, data_rdata;
    logic        mem_req, mem_wr, mem_uncached, mem_addr_ok, mem_data_ok;
    logic [1:0]  mem_size;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    mem_port_arbiter #(.KSEG1_UNCACHED(1'b1), .DATA_FIRST(1'b1)) dut (
        .clk(clk), .reset(reset),
        .inst_req(inst_req), .inst_addr(inst_addr), .inst_addr_ok(inst_addr_ok),
        .inst_data_ok(inst_data_ok), .inst_rdata(inst_rdata),
        .data_req(data_req), .data_wr(data_wr), .data_size(data_size),
        .data_addr(data_addr), .data_wdata(data_wdata), .data_addr_ok(data_addr_ok),
        .data_data_ok(data_data_ok), .data_rdata(data_rdata),
        .mem_req(mem_req), .mem_wr(mem_wr), .mem_size(mem_size), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_uncached(mem_uncached),
        .mem_addr_ok(mem_addr_ok), .mem_data_ok(mem_data_ok), .mem_rdata(mem_rdata)
    );

    typedef struct {
        string       name;
        logic        is_data;
        logic        wr;
        logic [1:0]  size;
        logic [31:0] vaddr;
        logic [31:0] wdata;
        logic [31:0] exp_addr;
        logic        exp_unc;
        logic        exp_wr;
        logic [1:0]  exp_size;
        logic [31:0] exp_wdata;
        logic [31:0] rdata;
    } vec_t;

    vec_t vecs[7];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Entered at posedge+1 with the arbiter in ADDR; leaves at posedge+1 back in IDLE.
    task automatic finish_txn(input string name, input logic own_data, input logic [31:0] rd);
        mem_addr_ok = 1'b1;
        step();
        mem_addr_ok = 1'b0;
        chk({name, " mem_req drop"}, 32'(mem_req), 32'd0);
        mem_data_ok = 1'b1;
        mem_rdata   = rd;
        #1;
        chk({name, " inst_data_ok"}, 32'(inst_data_ok), 32'(!own_data));
        chk({name, " data_data_ok"}, 32'(data_data_ok), 32'(own_data));
        chk({name, " rdata"}, own_data ? data_rdata : inst_rdata, rd);
        step();
        mem_data_ok = 1'b0;
    endtask

    task automatic do_txn(input vec_t v);
        if (v.is_data) begin
            data_req = 1'b1; data_wr = v.wr; data_size = v.size;
            data_addr = v.vaddr; data_wdata = v.wdata;
        end else begin
            inst_req = 1'b1; inst_addr = v.vaddr;
        end
        #1;
        chk({v.name, " inst_addr_ok"}, 32'(inst_addr_ok), 32'(!v.is_data));
        chk({v.name, " data_addr_ok"}, 32'(data_addr_ok), 32'(v.is_data));
        step();
        inst_req = 1'b0;
        data_req = 1'b0;
        chk({v.name, " mem_req"},      32'(mem_req), 32'd1);
        chk({v.name, " mem_addr"},     mem_addr, v.exp_addr);
        chk({v.name, " mem_uncached"}, 32'(mem_uncached), 32'(v.exp_unc));
        chk({v.name, " mem_wr"},       32'(mem_wr), 32'(v.exp_wr));
        chk({v.name, " mem_size"},     32'(mem_size), 32'(v.exp_size));
        chk({v.name, " mem_wdata"},    mem_wdata, v.exp_wdata);
        finish_txn(v.name, v.is_data, v.rdata);
    endtask

    initial begin
        vec_t v;
        logic inst_first;

        vecs[0] = '{"kseg1_fetch",  0, 0, 2'd2, 32'hBFC00000, 32'h0,        32'h1FC00000, 1, 0, 2'd2, 32'h0,        32'h3C080001};
        vecs[1] = '{"kseg0_store",  1, 1, 2'd2, 32'h80001004, 32'hDEADBEEF, 32'h00001004, 0, 1, 2'd2, 32'hDEADBEEF, 32'h0};
        vecs[2] = '{"kseg2_fetch",  0, 0, 2'd2, 32'hC0000010, 32'h0,        32'hC0000010, 0, 0, 2'd2, 32'h0,        32'h11112222};
        vecs[3] = '{"kuseg_loadb",  1, 0, 2'd0, 32'h7FFFFFFC, 32'h12345678, 32'h7FFFFFFC, 0, 0, 2'd0, 32'h12345678, 32'hA5A5A5A5};
        vecs[4] = '{"kseg0_9_ldh",  1, 0, 2'd1, 32'h90000ABC, 32'h0,        32'h10000ABC, 0, 0, 2'd1, 32'h0,        32'h0000CAFE};
        vecs[5] = '{"kseg1_A_fet",  0, 0, 2'd2, 32'hA0000100, 32'h0,        32'h00000100, 1, 0, 2'd2, 32'h0,        32'h55AA55AA};
        vecs[6] = '{"kseg1_B_sth",  1, 1, 2'd1, 32'hB1234566, 32'h0000BEEF, 32'h11234566, 1, 1, 2'd1, 32'h0000BEEF, 32'h0};

        reset = 1'b1;
        inst_req = 0; inst_addr = 0;
        data_req = 0; data_wr = 0; data_size = 0; data_addr = 0; data_wdata = 0;
        mem_addr_ok = 0; mem_data_ok = 0; mem_rdata = 0;

        // Reset state: outputs cleared, no acceptance or forwarding while reset is high.
        step(); step();
        chk("rst mem_req",  32'(mem_req), 32'd0);
        chk("rst mem_addr", mem_addr, 32'd0);
        chk("rst mem_wr",   32'(mem_wr), 32'd0);
        chk("rst mem_size", 32'(mem_size), 32'd0);
        chk("rst mem_wdata", mem_wdata, 32'd0);
        chk("rst mem_unc",  32'(mem_uncached), 32'd0);
        inst_req = 1; data_req = 1; mem_data_ok = 1;
        #1;
        chk("rst inst_addr_ok", 32'(inst_addr_ok), 32'd0);
        chk("rst data_addr_ok", 32'(data_addr_ok), 32'd0);
        chk("rst inst_data_ok", 32'(inst_data_ok), 32'd0);
        chk("rst data_data_ok", 32'(data_data_ok), 32'd0);
        step();
        chk("rst hold mem_req", 32'(mem_req), 32'd0);
        reset = 0; inst_req = 0; data_req = 0; mem_data_ok = 0;
        step();

        // First contention: data wins, inst granted the IDLE cycle after data's data_ok.
        inst_req = 1; inst_addr = 32'h00001000;
        data_req = 1; data_wr = 0; data_size = 2'd2; data_addr = 32'h00002000;
        #1;
        chk("cont1 data_addr_ok", 32'(data_addr_ok), 32'd1);
        chk("cont1 inst_addr_ok", 32'(inst_addr_ok), 32'd0);
        step();
        data_req = 0;
        #1;
        chk("cont1 mem_addr d", mem_addr, 32'h00002000);
        chk("cont1 inst held",  32'(inst_addr_ok), 32'd0);
        mem_addr_ok = 1;
        step();
        mem_addr_ok = 0; mem_data_ok = 1; mem_rdata = 32'h0BADF00D;
        #1;
        chk("cont1 data_data_ok", 32'(data_data_ok), 32'd1);
        chk("cont1 data_rdata",   data_rdata, 32'h0BADF00D);
        chk("cont1 no regrant",   32'(inst_addr_ok), 32'd0);
        step();
        mem_data_ok = 0;
        #1;
        chk("cont1 inst_addr_ok", 32'(inst_addr_ok), 32'd1);
        step();
        inst_req = 0;
        chk("cont1 mem_addr i", mem_addr, 32'h00001000);
        chk("cont1 mem_wr i",   32'(mem_wr), 32'd0);
        finish_txn("cont1 inst", 1'b0, 32'h01020304);

        for (int i = 0; i < 7; i++) do_txn(vecs[i]);

        // Second contention after a data win: round-robin favours inst, fixed favours data.
`ifdef MEM_ARB_RR_EN
        inst_first = 1'b1;
`else
        inst_first = 1'b0;
`endif
        inst_req = 1; inst_addr = 32'h80000040;
        data_req = 1; data_wr = 0; data_size = 2'd2; data_addr = 32'hA0000080;
        #1;
        chk("cont2 inst_addr_ok", 32'(inst_addr_ok), 32'(inst_first));
        chk("cont2 data_addr_ok", 32'(data_addr_ok), 32'(!inst_first));
        step();
        if (inst_first) inst_req = 0; else data_req = 0;
        chk("cont2 first addr", mem_addr, inst_first ? 32'h00000040 : 32'h00000080);
        chk("cont2 first unc",  32'(mem_uncached), 32'(!inst_first));
        finish_txn("cont2 first", !inst_first, 32'h77778888);
        #1;
        chk("cont2 second ok", 32'(inst_first ? data_addr_ok : inst_addr_ok), 32'd1);
        step();
        inst_req = 0; data_req = 0;
        chk("cont2 second addr", mem_addr, inst_first ? 32'h00000080 : 32'h00000040);
        finish_txn("cont2 second", inst_first, 32'h9999AAAA);

        // Bus stall with a spurious data_ok while waiting for addr_ok.
        inst_req = 1; inst_addr = 32'h00000200;
        #1;
        chk("stall grant", 32'(inst_addr_ok), 32'd1);
        step();
        inst_req = 0;
        for (int c = 0; c < 5; c++) begin
            mem_data_ok = (c == 2);
            #1;
            chk("stall mem_req",  32'(mem_req), 32'd1);
            chk("stall mem_addr", mem_addr, 32'h00000200);
            chk("stall no ok", 32'({inst_data_ok, data_data_ok}), 32'd0);
            step();
        end
        mem_data_ok = 0;
        finish_txn("stall done", 1'b0, 32'hFEEDFACE);

        // Reset while in DATA: transaction abandoned, late data_ok ignored.
        data_req = 1; data_wr = 0; data_size = 2'd2; data_addr = 32'h00003000;
        step();
        data_req = 0;
        mem_addr_ok = 1;
        step();
        mem_addr_ok = 0;
        reset = 1; mem_data_ok = 1;
        #1;
        chk("rstd ok in reset", 32'({inst_data_ok, data_data_ok}), 32'd0);
        mem_data_ok = 0;
        step();
        reset = 0;
        chk("rstd mem_req", 32'(mem_req), 32'd0);
        mem_data_ok = 1;
        #1;
        chk("rstd late ok", 32'({inst_data_ok, data_data_ok}), 32'd0);
        step();
        mem_data_ok = 0;
        v = '{"post_rst_fetch", 0, 0, 2'd2, 32'h00400000, 32'h0, 32'h00400000, 0, 0, 2'd2, 32'h0, 32'h24020001};
        do_txn(v);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares the single SRAM-like memory port between the instruction-fetch requester and the load/store requester.
- Applies the fixed MIPS segment translation at grant time:
  - kuseg and kseg2/3 pass through unchanged.
  - kseg0 (0x8/0x9) has 0x8 subtracted from the top nibble.
  - kseg1 (0xA/0xB) has 0xA subtracted from the top nibble.
- Sits between the pipeline's inst/data request interfaces and the bus bridge.
- Allows one outstanding transaction at a time.

Parameters:
- KSEG1_UNCACHED, 1: when 1, kseg1 addresses assert mem_uncached; when 0, mem_uncached is always 0.
- DATA_FIRST, 1: fixed-priority winner when both requesters are pending in IDLE (1 = data, 0 = inst).

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- inst_req  in  1  fetch request, held until inst_addr_ok
- inst_addr  in  32  virtual fetch address
- inst_addr_ok  out  1  fetch request accepted (combinational)
- inst_data_ok  out  1  fetch data valid (combinational)
- inst_rdata  out  32  fetch data
- data_req  in  1  load/store request, held until data_addr_ok
- data_wr  in  1  1 = store
- data_size  in  2  0 = byte, 1 = half, 2 = word
- data_addr  in  32  virtual data address
- data_wdata  in  32  store data
- data_addr_ok  out  1  data request accepted
- data_data_ok  out  1  load data valid / store complete
- data_rdata  out  32  load data
- mem_req  out  1  registered bus request
- mem_wr  out  1  registered
- mem_size  out  2  registered
- mem_addr  out  32  registered physical address
- mem_wdata  out  32  registered
- mem_uncached  out  1  registered
- mem_addr_ok  in  1  bus accepted the address
- mem_data_ok  in  1  bus data / write response
- mem_rdata  in  32  bus read data

Behaviour:
- States: IDLE, ADDR, DATA. An owner register holds INST or DATA.
- Reset (synchronous, active-high):
  - State goes to IDLE.
  - mem_req, mem_wr, mem_size, mem_addr, mem_wdata, mem_uncached all go to 0.
  - Owner goes to INST.
  - All *_ok outputs are 0 while reset is high.
- IDLE:
  - The winner among the pending requesters gets its *_addr_ok = 1 combinationally in the same cycle.
  - On that edge the arbiter latches the winner's wr/size/addr/wdata into the mem_* registers. Inst always latches wr = 0, size = 2, wdata = 0.
  - mem_req goes to 1 and the state moves to ADDR.
  - The loser sees addr_ok = 0 and must keep its request held.
- Translation (applied when latching), on virtual addr bits [31:28]:
  - 0x0–0x7: unchanged.
  - 0x8–0x9: top nibble minus 0x8.
  - 0xA–0xB: top nibble minus 0xA; mem_uncached = KSEG1_UNCACHED.
  - 0xC–0xF: unchanged.
  - Bits [27:0] always pass through.
- ADDR:
  - mem_req is held with all mem_* fields stable.
  - On mem_addr_ok = 1: mem_req goes to 0 next cycle and the state moves to DATA.
  - mem_data_ok is ignored in this state.
- DATA:
  - mem_data_ok is forwarded to the owner's *_data_ok and mem_rdata to the owner's *_rdata, combinationally.
  - The non-owner's data_ok is 0.
  - On mem_data_ok the state returns to IDLE.
  - A new grant can occur at the earliest one cycle after data_ok; there is no same-cycle re-grant.
- Minimum latency: accept at cycle 0, mem_req at cycle 1, mem_addr_ok at cycle 1, mem_data_ok at cycle 2, back in IDLE at cycle 3.
- Rdata outputs are don't-care when their data_ok = 0; the bench checks them only when data_ok = 1.
- Reset mid-transaction:
  - The arbiter abandons the transaction and drops mem_req at the next edge.
  - A mem_data_ok arriving after reset, while in IDLE, is ignored and not forwarded.
- Simultaneous mem_addr_ok and mem_data_ok while in ADDR: only addr_ok is honoured.

Optional Feature:
- MEM_ARB_RR_EN defined:
  - DATA_FIRST is ignored.
  - A last-winner bit (reset value: INST) gives priority, under contention, to the requester that did not win last.
  - The bit updates on every grant.
- MEM_ARB_RR_EN undefined: fixed priority per DATA_FIRST; data can starve fetch.

Test Plan:
- Inst-only read: inst_addr=0xBFC00000; bus returns addr_ok at cycle 1 and data_ok at cycle 2 with rdata 0x3C080001.
  - Expect mem_addr=0x1FC00000 and mem_uncached=1.
  - Expect inst_data_ok=1 with inst_rdata=0x3C080001 at cycle 2.
- kseg0 store: data_addr=0x80001004, wr=1, size=2, wdata=0xDEADBEEF.
  - Expect mem_addr=0x00001004, mem_wr=1, mem_uncached=0.
  - Expect data_data_ok on the bus data_ok; inst_data_ok stays 0.
- Contention: inst_req and data_req high together in IDLE with DATA_FIRST=1.
  - Data is granted first.
  - Inst is granted in the IDLE cycle after data's data_ok.
  - With MEM_ARB_RR_EN, a second contention grants inst first.
- Bus stall: mem_addr_ok held low for 5 cycles with a spurious mem_data_ok in cycle 2.
  - Expect mem_req and mem_addr stable throughout.
  - Expect no *_data_ok pulse.
  - Expect the transaction to complete normally after mem_addr_ok.
- Reset mid-DATA: assert reset for one cycle while in DATA, then pulse mem_data_ok.
  - Expect mem_req=0 after the reset edge.
  - Expect no *_data_ok pulse.
  - Expect a subsequent inst request with addr 0x00400000 to pass through as 0x00400000.
- Passthrough segments: addr 0xC0000010 maps to 0xC0000010 and 0x7FFFFFFC maps to 0x7FFFFFFC, both with uncached=0.
